// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage RISC-V pipeline.
// It detects load-use hazards and applies branch-redirect flushes over
// FLUSH_CYCLES fetch cycles. It freezes the whole pipeline while data memory
// is busy, and resumes the interrupted sequence when memory becomes ready.
// Every control output is combinational from the registered state and the
// current inputs.
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN adds the stall_count and
// flush_count performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32,
    parameter int FLUSH_CYCLES     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        branch_taken,
    input  logic                        ex_mem_read,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
    input  logic                        id_use_rs1,
    input  logic                        id_use_rs2,
    input  logic                        mem_busy,
    output logic                        pc_write,
    output logic                        if_id_hazard,
    output logic                        if_id_flush,
    output logic                        id_ex_flush,
    output logic                        ex_mem_hold,
    output logic [1:0]                  ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [WORD_BITWIDTH-1:0]    stall_count,
    output logic [WORD_BITWIDTH-1:0]    flush_count
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LDSTALL  = 2'd1,
        REDIRECT = 2'd2,
        MEMWAIT  = 2'd3
    } state_t;

    state_t           state, state_next;
    state_t           saved, saved_next;
    state_t           eff_state;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_next;
    logic             load_use;

    // The load in EX writes a register that the ID instruction really reads.
    // x0 is never a true dependency.
    function automatic logic detect_load_use(
        input logic                        mem_read,
        input logic [REG_NUM_BITWIDTH-1:0] rd,
        input logic [REG_NUM_BITWIDTH-1:0] rs1,
        input logic [REG_NUM_BITWIDTH-1:0] rs2,
        input logic                        use1,
        input logic                        use2
    );
        return mem_read && (rd != '0) &&
               ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

    assign load_use   = detect_load_use(ex_mem_read, ex_rd, id_rs1, id_rs2,
                                        id_use_rs1, id_use_rs2);
    assign ctrl_state = state;

    // State, saved state and flush counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            saved     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            saved     <= saved_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Next-state and control outputs. Priority: mem_busy > branch > load-use.
    always_comb begin
        state_next     = RUN;
        saved_next     = saved;
        flush_cnt_next = flush_cnt;
        pc_write       = 1'b1;
        if_id_hazard   = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_hold    = 1'b0;

        // While frozen, the pipeline behaves as the state that was interrupted.
        eff_state = (state == MEMWAIT) ? saved : state;

        if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_hazard = 1'b1;
            ex_mem_hold  = 1'b1;
            saved_next   = eff_state;
            state_next   = MEMWAIT;
        end else if (branch_taken) begin
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            flush_cnt_next = CNT_RELOAD;
            state_next     = (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
        end else begin
            unique case (eff_state)
                RUN: begin
                    if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_hazard = 1'b1;
                        id_ex_flush  = 1'b1;
                        state_next   = LDSTALL;
                    end
                end
                LDSTALL: begin
                    state_next = RUN;
                end
                REDIRECT: begin
                    if_id_flush = 1'b1;
                    if (flush_cnt != '0) begin
                        flush_cnt_next = flush_cnt - CNT_ONE;
                    end
                    state_next = (flush_cnt <= CNT_ONE) ? RUN : REDIRECT;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end

        // Reset forces every control output low, pc_write included.
        if (rst) begin
            pc_write     = 1'b0;
            if_id_hazard = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_hold  = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Performance counters: cycles with the PC stalled and cycles that flush IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write) begin
                stall_count <= stall_count + 1'b1;
            end
            if (if_id_flush) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Directed scenarios come first,
// followed by randomized traffic. A penalty-bookkeeping reference model
// tracks the branch flush cycles still owed, whether a load-use bubble is
// pending, and whether the pipeline is frozen.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int WW = 32;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          branch_taken, ex_mem_read, id_use_rs1, id_use_rs2, mem_busy;
    logic [RW-1:0] ex_rd, id_rs1, id_rs2;
    logic          pc_write, if_id_hazard, if_id_flush, id_ex_flush, ex_mem_hold;
    logic [1:0]    ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [WW-1:0] stall_count, flush_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int flush_left;
    bit bubble_owed;
    bit frozen;
    int m_stall, m_flush;

    pipeline_hazard_ctrl #(
        .REG_NUM_BITWIDTH(RW),
        .WORD_BITWIDTH(WW),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .branch_taken(branch_taken),
        .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .mem_busy(mem_busy),
        .pc_write(pc_write),
        .if_id_hazard(if_id_hazard),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .ex_mem_hold(ex_mem_hold),
        .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_count(stall_count),
        .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        flush_left  = 0;
        bubble_owed = 0;
        frozen      = 0;
        m_stall     = 0;
        m_flush     = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pc_write"}, 32'(pc_write), 0);
        check({tag, ".if_id_hazard"}, 32'(if_id_hazard), 0);
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 0);
        check({tag, ".id_ex_flush"}, 32'(id_ex_flush), 0);
        check({tag, ".ex_mem_hold"}, 32'(ex_mem_hold), 0);
        check({tag, ".ctrl_state"}, 32'(ctrl_state), 0);
    endtask

    // Apply one cycle of inputs at the falling edge, then check outputs and advance the model.
    task automatic cycle(input string tag, input logic b, input logic mr,
                         input logic [RW-1:0] rd, input logic [RW-1:0] r1,
                         input logic [RW-1:0] r2, input logic u1, input logic u2,
                         input logic mb);
        logic lu;
        logic e_pc, e_haz, e_iff, e_ief, e_hold;
        int   e_state;
        @(negedge clk);
        branch_taken = b;  ex_mem_read = mr; ex_rd = rd;
        id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2; mem_busy = mb;
        #1;
        lu = mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
        e_state = frozen ? 3 : (flush_left > 0) ? 2 : bubble_owed ? 1 : 0;
        e_pc = 1; e_haz = 0; e_iff = 0; e_ief = 0; e_hold = 0;
        if (mb) begin
            e_pc = 0; e_haz = 1; e_hold = 1;
            frozen = 1;
        end else begin
            frozen = 0;
            if (b) begin
                e_iff = 1; e_ief = 1;
                flush_left  = FC - 1;
                bubble_owed = 0;
            end else if (flush_left > 0) begin
                e_iff = 1;
                flush_left--;
            end else if (bubble_owed) begin
                bubble_owed = 0;
            end else if (lu) begin
                e_pc = 0; e_haz = 1; e_ief = 1;
                bubble_owed = 1;
            end
        end
        check({tag, ".pc_write"}, 32'(pc_write), 32'(e_pc));
        check({tag, ".if_id_hazard"}, 32'(if_id_hazard), 32'(e_haz));
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_iff));
        check({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(e_ief));
        check({tag, ".ex_mem_hold"}, 32'(ex_mem_hold), 32'(e_hold));
        check({tag, ".ctrl_state"}, 32'(ctrl_state), 32'(e_state));
        check({tag, ".hazard_and_flush"}, 32'(if_id_hazard && if_id_flush), 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check({tag, ".stall_count"}, stall_count, 32'(m_stall));
        check({tag, ".flush_count"}, flush_count, 32'(m_flush));
        if (!e_pc)  m_stall++;
        if (e_iff)  m_flush++;
`endif
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset between clock edges, check it acts at once, then release.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_clear();
        check_all_zero({tag, ".async"});
        @(posedge clk);
        #1;
        check_all_zero({tag, ".held"});
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check({tag, ".stall_count"}, stall_count, 0);
        check({tag, ".flush_count"}, flush_count, 0);
`endif
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        branch_taken = 0; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; mem_busy = 0;
        model_clear();
        #3;
        check_all_zero("reset_initial");
        mem_busy = 1; branch_taken = 1;
        #1;
        check_all_zero("reset_inputs_ignored");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Load-use held for two cycles: stall, bubble, then back to RUN.
        cycle("lu_c0", 0, 1, 5, 5, 0, 1, 0, 0);
        cycle("lu_c1", 0, 1, 5, 5, 0, 1, 0, 0);
        idle("lu_c2");
        check("lu_back_to_run", 32'(ctrl_state), 0);

        // x0 destination and unused source operands never stall.
        cycle("x0_no_stall", 0, 1, 0, 0, 0, 1, 0, 0);
        cycle("unused_rs1", 0, 1, 7, 7, 0, 0, 0, 0);
        cycle("lu_rs2", 0, 1, 9, 1, 9, 0, 1, 0);
        idle("lu_rs2_bubble");

        // Branch pulse, then branch together with a load-use.
        cycle("br_c0", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("br_c1");
        idle("br_c2");
        cycle("br_lu_c0", 1, 1, 3, 3, 0, 1, 0, 0);
        cycle("br_lu_c1", 0, 1, 3, 3, 0, 1, 0, 0);
        idle("br_lu_c2");
        cycle("br_restart", 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("br_restart2", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("br_restart3");

        // Memory busy for three cycles while REDIRECT has one flush cycle left.
        cycle("busy_br", 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("busy_c0", 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("busy_c1", 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("busy_c2", 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("busy_resume", 0, 0, 0, 0, 0, 0, 0, 0);
        idle("busy_run");

        // Busy interrupting a load-use bubble.
        cycle("lu_busy_c0", 0, 1, 4, 4, 0, 1, 0, 0);
        cycle("lu_busy_c1", 0, 1, 4, 4, 0, 1, 0, 1);
        cycle("lu_busy_c2", 0, 1, 4, 4, 0, 1, 0, 0);
        idle("lu_busy_c3");

        // Reset while frozen in MEMWAIT.
        cycle("memwait_enter", 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        do_reset("rst_memwait");
        mem_busy = 0; branch_taken = 0;
        idle("after_rst");
        check("after_rst_pc_write", 32'(pc_write), 1);

        // Reset in the middle of a redirect leaves no residual flush.
        cycle("rd_enter", 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        do_reset("rst_redirect");
        branch_taken = 0;
        idle("after_rst_rd");

        // Counter scenario: one load-use, one branch, three busy cycles.
        @(posedge clk);
        #2;
        do_reset("perf_rst");
        cycle("perf_lu", 0, 1, 5, 5, 0, 1, 0, 0);
        idle("perf_bubble");
        cycle("perf_br", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("perf_redirect");
        cycle("perf_busy0", 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("perf_busy1", 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("perf_busy2", 0, 0, 0, 0, 0, 0, 0, 1);
        idle("perf_end");
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check("perf_stall_total", stall_count, 4);
        check("perf_flush_total", flush_count, 2);
`endif

        // Randomized traffic with small register indices to provoke matches.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk);
                #2;
                do_reset("rand_rst");
            end
            cycle("rand",
                  ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)),
                  RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the IF/ID and ID/EX pipeline registers and the PC. It detects load-use hazards, applies branch-redirect flushes over a configurable fetch latency, and freezes the pipeline while data memory is busy. All control outputs are combinational from registered state plus current inputs, so each decision takes effect at the same clock edge.

## Interface
- REG_NUM_BITWIDTH, 5, register index width
- WORD_BITWIDTH, 32, width of performance counters
- FLUSH_CYCLES, 2, number of cycles if_id_flush is held after a taken branch (≥1)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- branch_taken  input  1  EX resolved a taken branch/jump this cycle
- ex_mem_read  input  1  instruction in EX is a load
- ex_rd  input  REG_NUM_BITWIDTH  destination register of EX instruction
- id_rs1, id_rs2  input  REG_NUM_BITWIDTH  source registers of ID instruction
- id_use_rs1, id_use_rs2  input  1  ID instruction actually reads rs1/rs2
- mem_busy  input  1  data memory not ready; whole pipeline must freeze
- pc_write  output  1  PC may update
- if_id_hazard  output  1  IF/ID register holds its contents
- if_id_flush  output  1  IF/ID register loads a NOP
- id_ex_flush  output  1  ID/EX register loads a bubble
- ex_mem_hold  output  1  EX/MEM and later registers hold
- ctrl_state  output  2  current FSM state (debug)

## Operation
- States: RUN=0, LDSTALL=1, REDIRECT=2, MEMWAIT=3. A flush counter flush_cnt is ceil(log2(FLUSH_CYCLES+1)) bits wide.
- Idle outputs: pc_write=1, all other control outputs 0.
- Load-use hazard: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
- Priority every cycle: mem_busy > branch_taken > load-use.
- mem_busy=1 in any state:
  - outputs: pc_write=0, if_id_hazard=1, ex_mem_hold=1, no flushes.
  - The current state is saved, flush_cnt is frozen, and the FSM enters MEMWAIT.
- MEMWAIT:
  - While mem_busy=1, stay and keep the freeze outputs.
  - On the first cycle with mem_busy=0, evaluate exactly as the saved state would: branch, then load-use, then that state's normal rules.
- branch_taken=1 (not busy), in any state:
  - outputs: pc_write=1, if_id_flush=1, id_ex_flush=1.
  - flush_cnt←FLUSH_CYCLES-1.
  - Next state is REDIRECT if FLUSH_CYCLES>1, else RUN.
  - A branch in REDIRECT restarts the counter.
- REDIRECT (no branch, not busy):
  - outputs: if_id_flush=1, pc_write=1.
  - flush_cnt decrements; at the transition to 0 the FSM goes to RUN.
  - Load-use detection is masked.
- RUN with load-use (no branch, not busy):
  - outputs: pc_write=0, if_id_hazard=1, id_ex_flush=1.
  - Next state is LDSTALL.
- LDSTALL: idle outputs, load-use masked, next state RUN. Exactly one bubble per load-use.
- if_id_hazard and if_id_flush are never both 1.

## Timing
- Zero-cycle decision latency: outputs respond combinationally in the same cycle as the inputs.
- State and flush_cnt update on posedge clk.
- Reset is asynchronous. While rst=1: state=RUN, flush_cnt=0, saved state=RUN, all outputs 0 including pc_write. After release, idle outputs apply.
- Reset mid-MEMWAIT or mid-REDIRECT abandons the sequence immediately; no residual flush after release.
- Taken-branch penalty is FLUSH_CYCLES cycles of if_id_flush. The load-use penalty is exactly 1 cycle.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: adds two outputs, stall_count and flush_count, each WORD_BITWIDTH bits, reset to 0.
  - stall_count increments on every cycle with pc_write=0 and rst=0.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both wrap modulo 2^WORD_BITWIDTH.
- Macro undefined: neither port nor counter exists. Control behaviour is identical in both builds.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 held 2 cycles → cycle 0: pc_write=0, if_id_hazard=1, id_ex_flush=1; cycle 1: LDSTALL, idle outputs; cycle 2: RUN.
- ex_rd=0 with ex_mem_read=1, id_rs1=0, id_use_rs1=1 → no stall; idle outputs.
- branch_taken pulse with FLUSH_CYCLES=2 → if_id_flush=1 for 2 cycles, id_ex_flush=1 only in the first, then RUN. Simultaneous load-use in the same cycle → branch outputs only, pc_write=1.
- mem_busy=1 for 3 cycles starting in REDIRECT with flush_cnt=1 → 3 freeze cycles (pc_write=0, ex_mem_hold=1, no flush), then 1 if_id_flush cycle, then RUN.
- Assert rst during MEMWAIT → all outputs 0 immediately (asynchronous). After release: RUN, pc_write=1.
- PERF build: 1 load-use, 1 branch (FLUSH_CYCLES=2), 3 busy cycles → stall_count=4, flush_count=2.
